// File: rtl/pipe_mux_pkg.sv
// Shared widths, pipeline latency and the stage-0 bundle for the pipelined bit mux/demux pair.
package pipe_mux_pkg;

    localparam int unsigned WORD_W  = 8;
    localparam int unsigned SEL_W   = 3;
    localparam int unsigned LATENCY = 2;

    // Input bundle captured by stage 0 and consumed by the accumulator stage.
    typedef struct packed {
        logic             valid;
        logic [SEL_W-1:0] sel;
        logic             data_bit;
        logic             last;
        logic             flush;
    } stage0_t;

endpackage : pipe_mux_pkg

// File: rtl/pipe_demux_accum.sv
// Stage 1 of pipe_demux_1_8: bit accumulator, written-bit mask and frame emit.
// Optional macro PIPE_DEMUX_COLLISION_EN adds collision_o (position written twice in a frame).
module pipe_demux_accum
    import pipe_mux_pkg::*;
#(
    parameter logic [WORD_W-1:0] FILL_WORD = 8'h00
) (
    input  logic              clk,
    input  logic              async_reset_n,
    input  stage0_t           i_s0,
    output logic              valid_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [WORD_W-1:0] output_word,
    output logic [WORD_W-1:0] mask_o
`ifdef PIPE_DEMUX_COLLISION_EN
    ,
    output logic              collision_o
`endif
);

    logic [WORD_W-1:0] r_accum;
    logic [WORD_W-1:0] r_mask;
    logic [WORD_W-1:0] w_onehot;
    logic [WORD_W-1:0] w_wr_word;
    logic [WORD_W-1:0] w_wr_mask;
    logic [WORD_W-1:0] w_accum_nxt;
    logic [WORD_W-1:0] w_mask_nxt;
    logic              w_emit;
`ifdef PIPE_DEMUX_COLLISION_EN
    logic [WORD_W-1:0] r_dup;
    logic [WORD_W-1:0] w_wr_dup;
    logic [WORD_W-1:0] w_dup_nxt;
`endif

    // Next accumulator/mask state; flush beats any same-cycle write or last.
    always_comb begin
        w_accum_nxt = r_accum;
        w_mask_nxt  = r_mask;
        w_emit      = 1'b0;
        w_onehot    = WORD_W'(1) << i_s0.sel;
        w_wr_word   = i_s0.data_bit ? (r_accum | w_onehot) : (r_accum & ~w_onehot);
        w_wr_mask   = r_mask | w_onehot;
`ifdef PIPE_DEMUX_COLLISION_EN
        w_dup_nxt   = r_dup;
        w_wr_dup    = r_dup | (r_mask & w_onehot);
`endif
        if (i_s0.flush) begin
            w_accum_nxt = FILL_WORD;
            w_mask_nxt  = '0;
`ifdef PIPE_DEMUX_COLLISION_EN
            w_dup_nxt   = '0;
`endif
        end else if (i_s0.valid && !i_s0.last) begin
            w_accum_nxt = w_wr_word;
            w_mask_nxt  = w_wr_mask;
`ifdef PIPE_DEMUX_COLLISION_EN
            w_dup_nxt   = w_wr_dup;
`endif
        end else if (i_s0.valid && i_s0.last) begin
            w_emit      = 1'b1;
            w_accum_nxt = FILL_WORD;
            w_mask_nxt  = '0;
`ifdef PIPE_DEMUX_COLLISION_EN
            w_dup_nxt   = '0;
`endif
        end
    end

    // Accumulator state plus output registers that hold between emits.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_accum     <= FILL_WORD;
            r_mask      <= '0;
            valid_o     <= 1'b0;
            sel_o       <= '0;
            output_word <= FILL_WORD;
            mask_o      <= '0;
`ifdef PIPE_DEMUX_COLLISION_EN
            r_dup       <= '0;
            collision_o <= 1'b0;
`endif
        end else begin
            r_accum <= w_accum_nxt;
            r_mask  <= w_mask_nxt;
            valid_o <= w_emit;
`ifdef PIPE_DEMUX_COLLISION_EN
            r_dup   <= w_dup_nxt;
`endif
            if (w_emit) begin
                output_word <= w_wr_word;
                mask_o      <= w_wr_mask;
                sel_o       <= i_s0.sel;
`ifdef PIPE_DEMUX_COLLISION_EN
                collision_o <= |w_wr_dup;
`endif
            end
        end
    end

endmodule : pipe_demux_accum

// File: rtl/pipe_demux_1_8.sv
// Pipelined 1:8 demux / bit-gatherer: stage-0 input registers feeding the accumulator stage.
// Optional macro PIPE_DEMUX_COLLISION_EN adds the collision_o output.
module pipe_demux_1_8
    import pipe_mux_pkg::*;
#(
    parameter logic [WORD_W-1:0] FILL_WORD = 8'h00
) (
    input  logic              clk,
    input  logic              async_reset_n,
    input  logic              valid_i,
    input  logic [SEL_W-1:0]  sel,
    input  logic              input_bit,
    input  logic              last_i,
    input  logic              flush_i,
    output logic              valid_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [WORD_W-1:0] output_word,
    output logic [WORD_W-1:0] mask_o
`ifdef PIPE_DEMUX_COLLISION_EN
    ,
    output logic              collision_o
`endif
);

    stage0_t r_s0;
    stage0_t w_s0;

    // Bundle the raw inputs for stage 0.
    always_comb begin
        w_s0          = '0;
        w_s0.valid    = valid_i;
        w_s0.sel      = sel;
        w_s0.data_bit = input_bit;
        w_s0.last     = last_i;
        w_s0.flush    = flush_i;
    end

    // Stage 0 input register.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_s0 <= '0;
        end else begin
            r_s0 <= w_s0;
        end
    end

    pipe_demux_accum #(
        .FILL_WORD (FILL_WORD)
    ) u_accum (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .i_s0          (r_s0),
        .valid_o       (valid_o),
        .sel_o         (sel_o),
        .output_word   (output_word),
        .mask_o        (mask_o)
`ifdef PIPE_DEMUX_COLLISION_EN
        ,
        .collision_o   (collision_o)
`endif
    );

endmodule : pipe_demux_1_8

// File: tb/tb_pipe_demux_1_8.sv
// Testbench for pipe_demux_1_8: directed frames plus random traffic against a frame-level model.
module tb_pipe_demux_1_8;
    import pipe_mux_pkg::*;

    localparam logic [7:0] FILL = 8'h00;

    logic       clk = 1'b0;
    logic       async_reset_n = 1'b1;
    logic       valid_i = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       input_bit = 1'b0;
    logic       last_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       valid_o;
    logic [2:0] sel_o;
    logic [7:0] output_word;
    logic [7:0] mask_o;
`ifdef PIPE_DEMUX_COLLISION_EN
    logic       collision_o;
`endif

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    pipe_demux_1_8 #(.FILL_WORD(FILL)) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .valid_i       (valid_i),
        .sel           (sel),
        .input_bit     (input_bit),
        .last_i        (last_i),
        .flush_i       (flush_i),
        .valid_o       (valid_o),
        .sel_o         (sel_o),
        .output_word   (output_word),
        .mask_o        (mask_o)
`ifdef PIPE_DEMUX_COLLISION_EN
        ,
        .collision_o   (collision_o)
`endif
    );

    typedef struct {
        logic       v;
        logic [7:0] w;
        logic [7:0] m;
        logic [2:0] s;
        logic       c;
    } exp_t;

    // Frame model: current partial word, per-position write counts, emit pipeline.
    logic [7:0] fr_word;
    int         wr_cnt [8];
    exp_t       pipe_q [$];
    exp_t       held;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        exp_t idle;
        idle = '{v: 1'b0, w: FILL, m: 8'h00, s: 3'd0, c: 1'b0};
        fr_word = FILL;
        for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
        pipe_q.delete();
        for (int i = 0; i < int'(LATENCY) - 1; i++) pipe_q.push_back(idle);
        held = idle;
    endtask

    task automatic clear_frame();
        fr_word = FILL;
        for (int i = 0; i < 8; i++) wr_cnt[i] = 0;
    endtask

    task automatic model_edge(input logic v, input logic [2:0] s, input logic b,
                              input logic l, input logic f, output exp_t r);
        r = '{v: 1'b0, w: FILL, m: 8'h00, s: 3'd0, c: 1'b0};
        if (f) begin
            clear_frame();
        end else if (v) begin
            fr_word[s] = b;
            wr_cnt[s]  = wr_cnt[s] + 1;
            if (l) begin
                r.v = 1'b1;
                r.w = fr_word;
                r.s = s;
                for (int i = 0; i < 8; i++) begin
                    if (wr_cnt[i] > 0) r.m[i] = 1'b1;
                    if (wr_cnt[i] > 1) r.c = 1'b1;
                end
                clear_frame();
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, check 1ns later.
    task automatic cycle(input logic v, input logic [2:0] s, input logic b,
                         input logic l, input logic f);
        exp_t r;
        exp_t e;
        @(negedge clk);
        valid_i = v; sel = s; input_bit = b; last_i = l; flush_i = f;
        @(posedge clk);
        model_edge(v, s, b, l, f, r);
        pipe_q.push_back(r);
        e = pipe_q.pop_front();
        if (e.v) held = e;
        #1;
        check("valid_o", 8'(valid_o), 8'(e.v));
        check("output_word", output_word, held.w);
        check("mask_o", mask_o, held.m);
        check("sel_o", 8'(sel_o), 8'(held.s));
`ifdef PIPE_DEMUX_COLLISION_EN
        if (e.v) check("collision_o", 8'(collision_o), 8'(e.c));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 8'(valid_o), 8'h00);
        check({tag, "_word"}, output_word, FILL);
        check({tag, "_mask"}, mask_o, 8'h00);
        check({tag, "_sel"}, 8'(sel_o), 8'h00);
`ifdef PIPE_DEMUX_COLLISION_EN
        check({tag, "_coll"}, 8'(collision_o), 8'h00);
`endif
    endtask

    initial begin
        logic [7:0] pattern;
        pattern = 8'b0100_1101;

        // Power-on reset
        #2 async_reset_n = 1'b0;
        #1 check_reset_outputs("por");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) async_reset_n = 1'b1;

        // Full frame sel 0..7, bits 1,0,1,1,0,0,1,0 -> 8'h4D / 8'hFF / sel 7
        for (int i = 0; i < 8; i++) cycle(1'b1, 3'(i), pattern[i], (i == 7), 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("full_word", output_word, 8'h4D);
        check("full_mask", mask_o, 8'hFF);

        // Partial frame -> 8'h24 / 8'h24
        cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3'd5, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("partial_word", output_word, 8'h24);

        // Back-to-back single-bit frames
        repeat (2) cycle(1'b1, 3'd3, 1'b1, 1'b1, 1'b0);
        repeat (3) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // last_i without valid_i is ignored
        cycle(1'b0, 3'd6, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // Flush beats a same-cycle last; following frame is clean
        cycle(1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3'd4, 1'b1, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 3'd0, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("post_flush_word", output_word, 8'h01);

        // Async reset mid-frame, between edges
        cycle(1'b1, 3'd6, 1'b1, 1'b0, 1'b0);
        valid_i = 1'b0; last_i = 1'b0; flush_i = 1'b0;
        #2 async_reset_n = 1'b0;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk) async_reset_n = 1'b1;
        cycle(1'b1, 3'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("midrst_mask", mask_o, 8'h01);

`ifdef PIPE_DEMUX_COLLISION_EN
        // Rewrite of one position flags a collision; next clean frame does not
        cycle(1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 3'd2, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 3'd7, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

        // Random traffic
        for (int n = 0; n < 500; n++) begin
            cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 15) == 0);
        end
        repeat (3) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_pipe_demux_1_8
